// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    // Default operand width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_add_cell.sv
// One-bit full adder assembled from two half-adder stages.
module bit_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder combines the operand bits; the second folds in the carry.
    always_comb begin
        ha0_s = a ^ b;
        ha0_c = a & b;
        s     = ha0_s ^ cin;
        ha1_c = ha0_s & cin;
        cout  = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first.
// Optional feature macro: SERIAL_ADD_SUB_EN enables subtraction via op=1.
// Without it, op is accepted but ignored and every operation is an addition.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADD_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_r;

    logic             sub_sel;
    logic             b_bit;
    logic             s_bit;
    logic             c_bit;

    // Subtraction is a + ~b + 1: invert b per bit and seed carry with 1.
    assign sub_sel = op_r & SUB_EN;
    assign b_bit   = b_r[cnt] ^ sub_sel;

    bit_add_cell u_cell (
        .a    (a_r[cnt]),
        .b    (b_bit),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // Operand capture; the held copies make the operation immune to input changes.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
        end
    end

    // Control FSM, bit counter, carry and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        carry  <= op & SUB_EN;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_r[cnt] <= s_bit;
                    carry      <= c_bit;
                    if (cnt == LAST_BIT) begin
                        cout_r <= c_bit;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = {cout_r, sum_r};

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy;
    logic         done;
    logic [W:0]   result;

    logic [W:0]   exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference arithmetic for the configured build.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic o);
`ifdef SERIAL_ADD_SUB_EN
        if (o) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Drive one start pulse at a falling edge and log the expected result.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          input logic [W:0] expv);
        @(negedge clk);
        a_i = x; b_i = y; op_i = o; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Watch for done (bounded), compare against the scoreboard, report busy cycles.
    task automatic wait_done(input string name, output int busy_cycles);
        logic [W:0] e;
        bit seen;
        seen = 0;
        busy_cycles = 0;
        for (int k = 0; k < W + 8; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                vectors++;
                if (result !== e) begin
                    miscompares++;
                    $display("FAIL %s: result=%h expected=%h", name, result, e);
                end
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: done=0 expected=1 within %0d cycles", name, W + 8);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a_i = 8'h11; b_i = 8'h22;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: busy=%b expected=0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: done=%b expected=0", done); end
        vectors++;
        if (result !== 9'h000) begin miscompares++; $display("FAIL rst_result: result=%h expected=000", result); end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: busy=%b expected=0", busy); end
    endtask

    task automatic test_add_basic;
        int cyc;
        launch(8'h03, 8'h05, 1'b0, 9'h008);
        wait_done("add_3_5", cyc);
        vectors++;
        if (cyc != 9) begin miscompares++; $display("FAIL add_busy_cycles: cycles=%0d expected=9", cyc); end
        @(negedge clk);
        a_i = 8'hAA; b_i = 8'h55;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse: done=%b expected=0", done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_done: busy=%b expected=0", busy); end
        repeat (2) @(negedge clk);
        vectors++;
        if (result !== 9'h008) begin miscompares++; $display("FAIL result_hold: result=%h expected=008", result); end
    endtask

    task automatic test_overflow;
        int cyc;
        launch(8'hFF, 8'h01, 1'b0, 9'h100);
        wait_done("add_ff_01", cyc);
        launch(8'hFF, 8'hFF, 1'b0, 9'h1FE);
        wait_done("add_ff_ff", cyc);
    endtask

    task automatic test_sub;
        int cyc;
`ifdef SERIAL_ADD_SUB_EN
        launch(8'h05, 8'h07, 1'b1, 9'h0FE);
        wait_done("sub_5_7", cyc);
        launch(8'h07, 8'h05, 1'b1, 9'h102);
        wait_done("sub_7_5", cyc);
        launch(8'h40, 8'h40, 1'b1, 9'h100);
        wait_done("sub_equal", cyc);
`else
        launch(8'h05, 8'h07, 1'b1, 9'h00C);
        wait_done("op_ignored_5_7", cyc);
        launch(8'hF0, 8'h20, 1'b1, 9'h110);
        wait_done("op_ignored_f0_20", cyc);
`endif
    endtask

    task automatic test_start_held;
        int dones;
        int cyc;
        @(negedge clk);
        a_i = 8'h10; b_i = 8'h20; op_i = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        dones = 0;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                vectors++;
                if (result !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL held_first: result=%h expected=%h", result, exp_q[0]);
                end
                void'(exp_q.pop_front());
                a_i = 8'h33; b_i = 8'h44;
                exp_q.push_back(model(8'h33, 8'h44, 1'b0));
            end else begin
                a_i = 8'($urandom);
            end
        end
        vectors++;
        if (dones != 1) begin miscompares++; $display("FAIL held_done_count: dones=%0d expected=1", dones); end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_idle_gap: busy=%b done=%b expected=0/0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL back_to_back_accept: busy=%b expected=1", busy); end
        wait_done("back_to_back", cyc);
    endtask

    task automatic test_reset_abort;
        int dones;
        @(negedge clk);
        a_i = 8'h12; b_i = 8'h34; op_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 9'h000) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b done=%b result=%h expected=0/0/000", busy, done, result);
        end
        dones = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) dones++;
        end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL abort_no_done: dones=%0d expected=0", dones); end
    endtask

    task automatic test_random;
        int cyc;
        logic [W-1:0] x, y;
        logic o;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            o = 1'($urandom);
            launch(x, y, o, model(x, y, o));
            wait_done("random", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_overflow();
        test_sub();
        test_start_held();
        test_reset_abort();
        test_random();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
